// File: rtl/conv_seq_ctrl.sv
// Streams input then weight words from word memory into conv_top and writes results back.
// Latency: start -> first read +1, read -> conv word +1; no backpressure (engine must accept every word).
module conv_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [LEN_W-1:0]  cfg_in_len,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [LEN_W-1:0]  cfg_wt_len,
  input  logic [ADDR_W-1:0] cfg_out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              conv_start,
  output logic [DATA_W-1:0] conv_data,
  output logic              conv_valid,
  output logic              conv_dtype,
  input  logic [DATA_W-1:0] conv_odata,
  input  logic              conv_ovalid,
  input  logic              conv_finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  out_cnt
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IN, S_LOAD_WT, S_DRAIN, S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wt_base_q, wt_base_d;
  logic [LEN_W-1:0]  wt_len_q, wt_len_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_phase_q, rd_phase_d;
  logic              conv_valid_q, conv_valid_d;
  logic              conv_dtype_q, conv_dtype_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0] wr_ofs_q, wr_ofs_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // Write-back is open in every busy state, so results may overlap the load.
  assign wr_en      = conv_ovalid & busy_q;
  assign wr_addr    = out_base_q + wr_ofs_q;
  assign wr_data    = conv_odata;
  assign conv_data  = rd_data;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign conv_valid = conv_valid_q;
  assign conv_start = conv_valid_q;
  assign conv_dtype = conv_dtype_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign out_cnt    = out_cnt_q;

  always_comb begin
    state_d      = state_q;
    wt_base_d    = wt_base_q;
    wt_len_d     = wt_len_q;
    out_base_d   = out_base_q;
    rem_d        = rem_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_phase_d   = rd_phase_q;
    conv_valid_d = rd_en_q;
    conv_dtype_d = rd_en_q & rd_phase_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    out_cnt_d    = out_cnt_q;
    wr_ofs_d     = wr_ofs_q;
    tmo_d        = tmo_q;

    // The result address keeps advancing after the count saturates.
    if (wr_en) begin
      wr_ofs_d  = wr_ofs_q + ADDR_ONE;
      out_cnt_d = (out_cnt_q == CNT_MAX) ? out_cnt_q : out_cnt_q + LEN_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          wt_base_d  = cfg_wt_base;
          wt_len_d   = cfg_wt_len;
          out_base_d = cfg_out_base;
          out_cnt_d  = '0;
          wr_ofs_d   = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          tmo_d      = '0;
          if (cfg_in_len != '0) begin
            state_d    = S_LOAD_IN;
            rd_en_d    = 1'b1;
            rd_addr_d  = cfg_in_base;
            rem_d      = cfg_in_len - LEN_ONE;
            rd_phase_d = 1'b0;
          end else if (cfg_wt_len != '0) begin
            state_d    = S_LOAD_WT;
            rd_en_d    = 1'b1;
            rd_addr_d  = cfg_wt_base;
            rem_d      = cfg_wt_len - LEN_ONE;
            rd_phase_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_LOAD_IN: begin
        if (rem_q == '0) begin
          if (wt_len_q != '0) begin
            state_d    = S_LOAD_WT;
            rd_en_d    = 1'b1;
            rd_addr_d  = wt_base_q;
            rem_d      = wt_len_q - LEN_ONE;
            rd_phase_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rem_d     = rem_q - LEN_ONE;
        end
      end
      S_LOAD_WT: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rem_d     = rem_q - LEN_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
        tmo_d   = '0;
      end
      S_RUN: begin
        // A finish on the last allowed cycle still counts as a clean completion.
        if (conv_finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wt_base_q    <= '0;
      wt_len_q     <= '0;
      out_base_q   <= '0;
      rem_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_phase_q   <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_dtype_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      out_cnt_q    <= '0;
      wr_ofs_q     <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      wt_base_q    <= wt_base_d;
      wt_len_q     <= wt_len_d;
      out_base_q   <= out_base_d;
      rem_q        <= rem_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_phase_q   <= rd_phase_d;
      conv_valid_q <= conv_valid_d;
      conv_dtype_q <= conv_dtype_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      out_cnt_q    <= out_cnt_d;
      wr_ofs_q     <= wr_ofs_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule
